// File: rtl/chunked_serial_adder_pkg.sv
// ============================================================================
// chunked_serial_adder_pkg : FSM state encoding shared by the chunked adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/chunked_serial_adder_rca.sv
// ============================================================================
// ripple_carry_adder : SIZE-bit ripple-carry adder exposing every bit carry
// Revision: 1.0
// ============================================================================
`default_nettype none

module ripple_carry_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            cin_i,
  output logic [SIZE-1:0] sum_o,
  output logic [SIZE-1:0] cout_o
);

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    logic carry_in;
    if (i == 0) begin : g_first
      assign carry_in = cin_i;
    end else begin : g_rest
      assign carry_in = cout_o[i-1];
    end
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ carry_in;
    assign cout_o[i] = (a_i[i] & b_i[i]) | (carry_in & (a_i[i] ^ b_i[i]));
  end

endmodule

`default_nettype wire

// File: rtl/chunked_serial_adder.sv
// ============================================================================
// chunked_serial_adder : WIDTH-bit add, CHUNK bits per clock, valid/ready I/O
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk, chunk_sum, chunk_cout;
  logic               last_chunk;

  assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == IDX_W'(NCH - 1));

  ripple_carry_adder #(.SIZE(CHUNK)) u_rca (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout[CHUNK-1];
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          // The final chunk's MSB is the sum sign bit, so overflow is decided here.
          cout_d  = chunk_cout[CHUNK-1];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
// ============================================================================
// tb_chunked_serial_adder : vector table, corner sequences and random ops
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chunked_serial_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                       output logic [31:0] ms, output logic mco, output logic mov);
    longint unsigned u;
    longint          s;
    u   = longint'(ma) + longint'(mb) + longint'(mc);
    ms  = u[31:0];
    mco = u[32];
    s   = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    mov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic [31:0] es, input logic ec, input logic eo);
    int waitc;
    int lat;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({name, "_in_ready"}, 64'(in_ready), 64'(1));
    a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(NCH));
    check({name, "_sum"}, 64'(sum), 64'(es));
    check({name, "_cout"}, 64'(cout), 64'(ec));
    check({name, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] ms, held_sum;
    logic        mc, mo, held_c, held_o;
    logic [31:0] ra, rb;
    logic        rc;
    int          waitc;
    bit          seen;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h0FEDCBA8, 1'b1, 32'h22222221, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Backpressure: results must hold and new operands must be ignored.
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    a = 32'h12345678; b = 32'h0FEDCBA8; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 50) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    held_sum = 32'h22222221; held_c = 1'b0; held_o = 1'b0;
    check("bp_first_sum", 64'(sum), 64'(held_sum));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; cin = 1'($urandom); in_valid = 1'($urandom_range(0, 1)) | (k == 0);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_hold", {31'd0, cout, overflow, sum}, {31'd0, held_c, held_o, held_sum});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 64'(out_valid), 64'(0));
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    run_op("bp_next", 32'hDEADBEEF, 32'h21524111, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // Reset after two chunks of an op.
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_outputs", {31'd0, cout, overflow, sum}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("aborted_no_valid", 64'(seen), 64'(0));
    run_op("after_rst", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      if (i % 6 == 0) rb = ~ra;
      model(ra, rb, rc, ms, mc, mo);
      run_op($sformatf("rand%0d", i), ra, rb, rc, ms, mc, mo);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

- Multi-cycle WIDTH-bit adder: processes CHUNK bits per clock through one CHUNK-bit ripple-carry adder and a registered carry.
- Operands arrive on a valid/ready input handshake; sum, carry-out and signed overflow leave on a valid/ready output handshake.
- Sits upstream of result consumers (accumulators, ALU writeback). Trades latency for a short carry chain.

## Interface

Parameters:
- WIDTH, 32, operand/sum width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per cycle; NCH = WIDTH/CHUNK chunks per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow.

## Operation

- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register a, b and cin (cin loads the carry register), clear chunk index idx to 0, clear the sum register, go to RUN.
- RUN:
  - Each cycle, chunk idx computes a[idx*CHUNK +: CHUNK] + b[same] + carry.
  - The result is written into sum[idx*CHUNK +: CHUNK]; carry takes the chunk carry-out; idx increments.
  - When idx == NCH-1 is processed, go to DONE.
  - cout takes the final chunk carry.
  - overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), using registered operands; registered on entry to DONE.
- DONE:
  - out_valid = 1.
  - sum, cout and overflow are held stable until out_ready is high.
  - On out_valid && out_ready, go to IDLE.
- in_ready = (state == IDLE) && !rst. It is 0 in RUN and DONE. in_valid in those states is ignored; the operands are not captured.
- No accept in the DONE→IDLE handoff cycle: one operation is in flight at a time.
- Operand inputs are don't-care except in the accept cycle. Registered copies are used throughout.
- Reset values: out_valid 0, sum 0, cout 0, overflow 0, idx 0, carry 0, state IDLE. in_ready is 0 while rst is high.
- Reset mid-operation (RUN or DONE):
  - The operation is aborted and its result is discarded.
  - out_valid is never asserted for it.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the true unsigned carry. overflow is valid for signed interpretation, including the cin=1 case.
- NCH = 1 is legal: RUN lasts one cycle.

## Timing

- Accept at edge E0 (in_valid && in_ready sampled high).
- Chunk k is registered at edge E(k+1).
- out_valid rises after edge E(NCH), i.e. NCH cycles after accept.
- Minimum op period with out_ready held high is NCH+2 cycles: 1 IDLE + NCH RUN + 1 DONE.
- Backpressure: DONE persists indefinitely while out_ready=0. Outputs do not change.
- in_ready returns to 1 in the cycle after the output handshake edge.
- Combinational path per cycle is limited to one CHUNK-bit ripple plus register setup.

## Structure

- Shared package holds the FSM state typedef (IDLE/RUN/DONE encoding) only.
- NCH and the idx width ($clog2(NCH), minimum 1) are module localparams.
- One sub-module: ripple_carry_adder with SIZE=CHUNK, instantiated once. The chunk carry is taken from its Cout[CHUNK-1].
- Elaboration-time check: WIDTH % CHUNK == 0 and CHUNK >= 1.

## Test plan

All scenarios use WIDTH=32, CHUNK=8.

- 0x000000FF + 0x00000001, cin=0 → sum 0x00000100, cout 0, overflow 0; out_valid rises exactly 4 cycles after accept.
- 0xFFFFFFFF + 0x00000001, cin=0 → sum 0x00000000, cout 1, overflow 0. Carry propagates through all 4 chunks.
- 0x7FFFFFFF + 0x00000001 → sum 0x80000000, cout 0, overflow 1. Separately, 0x80000000 + 0x80000000 → sum 0, cout 1, overflow 1.
- 0x12345678 + 0x0FEDCBA8, cin=1 → sum 0x22222221, cout 0, overflow 0.
- Backpressure: out_ready held 0 for 5 cycles in DONE, with in_valid pulsed and different operands driven meanwhile → sum, cout and overflow unchanged; in_ready 0; new operands not taken. Raise out_ready → in_ready 1 next cycle, and the next op computes correctly.
- Assert rst for 1 cycle after 2 chunks of an op → out_valid never asserts for it; outputs read 0; in_ready is 1 in the first cycle after rst deasserts. A following 5 + 3 → 8.
